fir_coe_loader: RTL and testbench

Coefficient loader that sits directly upstream of the FIR datapath and drives its flat `coe_i` bus. It accepts coefficients as a serial valid/ready stream with a frame-end marker and writes them into a shadow bank. It copies the shadow bank atomically into the active bank only after a complete, correctly-sized frame has been received. The filter therefore never sees a partially-updated coefficient set.

---
 rtl/fir_coe_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_fir_coe_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coe_loader.sv
// fir_coe_loader
// Coefficient loader that sits directly upstream of the FIR datapath.
// - Coefficients arrive as a serial valid/ready stream. Each frame ends with a wr_last_i marker.
// - Beats are written in order into a shadow bank.
// - The shadow bank is copied into the active bank (coe_o) in one cycle, and only after a
//   frame of exactly COE_NUM beats. The filter never sees a half-written coefficient set.
// - Short frames are rejected with err_o and the active bank is left untouched.
// - Long frames are rejected with err_o, and their remaining beats are drained up to wr_last_i.
// Optional feature: define FIR_COE_READBACK_EN to add the rd_idx_i / rd_data_o readback port.
// That port is a registered, 1-cycle-latency read of the active bank; an out-of-range index
// returns 0.
module fir_coe_loader #(
    parameter int COE_WIDTH = 16,
    parameter int COE_NUM   = 20,
    parameter int CNT_WIDTH = $clog2(COE_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_vld_i,
    output logic                         wr_rdy_o,
    input  logic [COE_WIDTH-1:0]         wr_data_i,
    input  logic                         wr_last_i,
`ifdef FIR_COE_READBACK_EN
    input  logic [CNT_WIDTH-1:0]         rd_idx_i,
    output logic [COE_WIDTH-1:0]         rd_data_o,
`endif
    output logic [COE_WIDTH*COE_NUM-1:0] coe_o,
    output logic                         coe_upd_o,
    output logic                         err_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Index of the final coefficient of a frame.
    localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(COE_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    // A last marker on the very first beat is only legal for a one-coefficient frame.
    localparam logic                 MULTI_BEAT = (COE_NUM > 1) ? 1'b1 : 1'b0;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_nxt_s;

    logic                   wr_rdy_s;
    logic                   busy_s;
    logic                   beat_acc_s;
    logic                   sh_we_s;
    logic [CNT_WIDTH-1:0]   sh_idx_s;
    logic                   err_s;
    logic                   commit_s;

    logic [COE_WIDTH-1:0]   shadow_r [COE_NUM];
    logic [COE_WIDTH-1:0]   active_r [COE_NUM];
    logic                   coe_upd_r;
    logic                   err_r;

    // State register and beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output decode of the registered state (ready and busy flags)
    always_comb begin
        wr_rdy_s = 1'b1;
        busy_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_rdy_s = 1'b1;
                busy_s   = 1'b0;
            end
            ST_LOAD: begin
                wr_rdy_s = 1'b1;
                busy_s   = 1'b1;
            end
            ST_DRAIN: begin
                wr_rdy_s = 1'b1;
                busy_s   = 1'b1;
            end
            ST_COMMIT: begin
                wr_rdy_s = 1'b0;
                busy_s   = 1'b1;
            end
            default: begin
                wr_rdy_s = 1'b1;
                busy_s   = 1'b0;
            end
        endcase
    end

    assign beat_acc_s = wr_vld_i & wr_rdy_s;

    // Next-state, counter, shadow-write and error/commit decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sh_we_s     = 1'b0;
        sh_idx_s    = cnt_r;
        err_s       = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // First beat of a frame always lands in slot 0.
                sh_idx_s = CNT_ZERO;
                if (beat_acc_s) begin
                    sh_we_s = 1'b1;
                    if (wr_last_i && MULTI_BEAT) begin
                        err_s       = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_acc_s) begin
                    sh_we_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        if (wr_last_i) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = ST_COMMIT;
                        end else begin
                            // Long frame: reject now, swallow the tail until last.
                            err_s       = 1'b1;
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = ST_DRAIN;
                        end
                    end else begin
                        if (wr_last_i) begin
                            // Short frame: reject, active bank untouched.
                            err_s       = 1'b1;
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            cnt_nxt_s   = cnt_r + CNT_ONE;
                            state_nxt_s = ST_LOAD;
                        end
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (beat_acc_s && wr_last_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_COMMIT: begin
                commit_s    = 1'b1;
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shadow bank: collects the beats of the frame in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < COE_NUM; k++) begin
                shadow_r[k] <= {COE_WIDTH{1'b0}};
            end
        end else if (sh_we_s) begin
            shadow_r[sh_idx_s] <= wr_data_i;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active bank: updated atomically from the shadow bank on commit only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < COE_NUM; k++) begin
                active_r[k] <= {COE_WIDTH{1'b0}};
            end
        end else if (commit_s) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Registered status pulses; commit and error can never coincide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coe_upd_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            coe_upd_r <= commit_s;
            err_r     <= err_s;
        end
    end

    // Flatten the active bank onto the FIR coefficient bus
    genvar gk;
    generate
        for (gk = 0; gk < COE_NUM; gk++) begin : g_flat
            assign coe_o[gk*COE_WIDTH +: COE_WIDTH] = active_r[gk];
        end
    endgenerate

    assign wr_rdy_o  = wr_rdy_s;
    assign busy_o    = busy_s;
    assign coe_upd_o = coe_upd_r;
    assign err_o     = err_r;

`ifdef FIR_COE_READBACK_EN
    logic [COE_WIDTH-1:0] rd_data_r;

    // Registered readback of one active-bank coefficient; out-of-range reads return 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= {COE_WIDTH{1'b0}};
        end else if (int'(rd_idx_i) < COE_NUM) begin
            rd_data_r <= active_r[rd_idx_i];
        end else begin
            rd_data_r <= {COE_WIDTH{1'b0}};
        end
    end

    assign rd_data_o = rd_data_r;
`endif

endmodule

// File: tb/tb_fir_coe_loader.sv
// tb_fir_coe_loader
// Directed bench for fir_coe_loader (COE_NUM=20, COE_WIDTH=16).
// Expected banks are queued when a good frame is driven and popped when coe_upd_o pulses.
module tb_fir_coe_loader;
    localparam int W  = 16;
    localparam int N  = 20;
    localparam int CW = $clog2(N);
    localparam int VW = W * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_vld;
    logic          wr_last;
    logic [W-1:0]  wr_data;
    logic          wr_rdy;
    logic          coe_upd;
    logic          err;
    logic          busy;
    logic [VW-1:0] coe;
`ifdef FIR_COE_READBACK_EN
    logic [CW-1:0] rd_idx;
    logic [W-1:0]  rd_data;
`endif

    int            n_cmp    = 0;
    int            n_fail   = 0;
    int            upd_seen = 0;
    int            err_seen = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] bank_model;
    logic [W-1:0]  beats[$];

    always #5 clk = ~clk;

    fir_coe_loader #(.COE_WIDTH(W), .COE_NUM(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_vld_i  (wr_vld),
        .wr_rdy_o  (wr_rdy),
        .wr_data_i (wr_data),
        .wr_last_i (wr_last),
`ifdef FIR_COE_READBACK_EN
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
`endif
        .coe_o     (coe),
        .coe_upd_o (coe_upd),
        .err_o     (err),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: wait for the falling edge, then score any pulse the DUT produced.
    task automatic tick();
        logic [VW-1:0] e;
        @(negedge clk);
        if (coe_upd === 1'b1) begin
            upd_seen++;
            chk("upd_expected", VW'(exp_q.size() > 0), VW'(1));
            chk("upd_err_exclusive", VW'(err), VW'(0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("coe_on_upd", coe, e);
            end
        end
        if (err === 1'b1) begin
            err_seen++;
        end
    endtask

    function automatic logic [VW-1:0] pack_beats();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*W +: W] = beats[k];
        end
        return v;
    endfunction

    // Push nb beats from the beats queue, with an optional last marker on the final one.
    // err_at: beat index after which err_o must be high (-1 for none).
    task automatic send(input int nb, input bit use_last, input int err_at, input bit rnd);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < nb && guard < 2000) begin
            wr_vld  = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            wr_data = beats[i];
            wr_last = use_last && (i == nb - 1);
            acc     = wr_vld && wr_rdy;
            tick();
            guard++;
            if (acc) begin
                if (i == err_at) begin
                    chk("err_pulse_timing", VW'(err), VW'(1));
                end
                i++;
            end
        end
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        chk("send_complete", VW'(i), VW'(nb));
    endtask

    task automatic good_frame(input bit rnd);
        int e0;
        int u0;
        e0 = err_seen;
        u0 = upd_seen;
        bank_model = pack_beats();
        exp_q.push_back(bank_model);
        send(N, 1'b1, -1, rnd);
        chk("rdy_low_in_commit", VW'(wr_rdy), VW'(0));
        chk("busy_in_commit", VW'(busy), VW'(1));
        tick();
        chk("rdy_back_after_commit", VW'(wr_rdy), VW'(1));
        chk("upd_pulse_count", VW'(upd_seen - u0), VW'(1));
        chk("no_err_good_frame", VW'(err_seen - e0), VW'(0));
        chk("coe_after_commit", coe, bank_model);
        tick();
        chk("upd_single_cycle", VW'(coe_upd), VW'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int u0;
        rst_n   = 1'b0;
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        wr_data = '0;
`ifdef FIR_COE_READBACK_EN
        rd_idx  = '0;
`endif
        bank_model = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_coe", coe, '0);
        chk("reset_rdy", VW'(wr_rdy), VW'(1));
        chk("reset_busy", VW'(busy), VW'(0));
        chk("reset_upd", VW'(coe_upd), VW'(0));
        chk("reset_err", VW'(err), VW'(0));

        // Good frame: k+1
        beats.delete();
        for (int k = 0; k < N; k++) beats.push_back(W'(k + 1));
        good_frame(1'b0);
`ifdef FIR_COE_READBACK_EN
        rd_idx = CW'(7);
        tick();
        chk("readback_idx7", VW'(rd_data), VW'(8));
        rd_idx = CW'(25);
        tick();
        chk("readback_out_of_range", VW'(rd_data), VW'(0));
`endif

        // Short frame: last on beat 5
        e0 = err_seen;
        u0 = upd_seen;
        beats.delete();
        for (int k = 0; k < 6; k++) beats.push_back(W'(16'hA000 + k));
        send(6, 1'b1, 5, 1'b0);
        chk("short_err_count", VW'(err_seen - e0), VW'(1));
        chk("short_busy_idle", VW'(busy), VW'(0));
        chk("short_coe_kept", coe, bank_model);
        tick();
        chk("short_err_single", VW'(err), VW'(0));
        chk("short_no_upd", VW'(upd_seen - u0), VW'(0));

        // Good frame after the short one
        beats.delete();
        for (int k = 0; k < N; k++) beats.push_back(W'(100 + 3 * k));
        good_frame(1'b0);

        // Long frame: 25 beats, error after beat 19, drain the rest
        e0 = err_seen;
        u0 = upd_seen;
        beats.delete();
        for (int k = 0; k < 25; k++) beats.push_back(W'(16'h5500 + k));
        send(25, 1'b1, 19, 1'b0);
        chk("long_err_count", VW'(err_seen - e0), VW'(1));
        chk("long_busy_idle", VW'(busy), VW'(0));
        chk("long_rdy", VW'(wr_rdy), VW'(1));
        tick();
        chk("long_coe_kept", coe, bank_model);
        chk("long_no_upd", VW'(upd_seen - u0), VW'(0));

        // Random-valid frame with extreme values
        beats.delete();
        for (int k = 0; k < N; k++) beats.push_back((k % 2 == 0) ? 16'h8000 : 16'h7FFF);
        good_frame(1'b1);

        // Reset at beat 10 of a frame
        e0 = err_seen;
        u0 = upd_seen;
        beats.delete();
        for (int k = 0; k < N; k++) beats.push_back(W'(16'h1234 + k));
        send(10, 1'b0, -1, 1'b0);
        chk("mid_frame_busy", VW'(busy), VW'(1));
        rst_n   = 1'b0;
        wr_vld  = 1'b1;
        wr_data = beats[10];
        tick();
        rst_n  = 1'b1;
        wr_vld = 1'b0;
        bank_model = '0;
        chk("abort_coe_zero", coe, '0);
        chk("abort_busy", VW'(busy), VW'(0));
        chk("abort_rdy", VW'(wr_rdy), VW'(1));
        tick();
        chk("abort_no_upd", VW'(upd_seen - u0), VW'(0));
        chk("abort_no_err", VW'(err_seen - e0), VW'(0));

        // Full frame after the abort
        beats.delete();
        for (int k = 0; k < N; k++) beats.push_back(W'(k + 1));
        good_frame(1'b0);
`ifdef FIR_COE_READBACK_EN
        rd_idx = CW'(7);
        tick();
        chk("readback_after_abort", VW'(rd_data), VW'(8));
`endif

        chk("scoreboard_drained", VW'(exp_q.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
